// File: rtl/bloke2s_pkg.sv
// Shared types for the bloke2s host: FSM states, result flags and the default digest size.
package bloke2s_pkg;

  localparam int DIGEST_BYTES_DFLT = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    FINISH,
    COLLECT,
    DONE
  } state_e;

  typedef struct packed {
    logic match;
    logic len_err;
    logic timeout;
  } result_t;

endpackage

// File: rtl/bloke2s_host_if.sv
// Bundle of message-stream, core-handshake and result signals around one bloke2s host.
interface bloke2s_host_if #(
  parameter int DIGEST_BYTES = bloke2s_pkg::DIGEST_BYTES_DFLT
);

  localparam int DW = 8 * DIGEST_BYTES;

  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic          s_empty;
  logic [DW-1:0] exp_digest;

  logic          hs_start;
  logic          hs_finish;
  logic [7:0]    hs_din;
  logic          hs_din_valid;
  logic          hs_din_ready;
  logic          hs_din_end;
  logic [7:0]    hs_dout;
  logic          hs_dout_valid;
  logic          hs_dout_end;

  logic          res_valid;
  logic          res_match;
  logic          res_len_err;
  logic          res_timeout;
  logic [DW-1:0] digest;
  logic          busy;

  modport master (
    input  s_data, s_valid, s_last, s_empty, exp_digest,
    input  hs_din_ready, hs_dout, hs_dout_valid, hs_dout_end,
    output s_ready, hs_start, hs_finish, hs_din, hs_din_valid, hs_din_end,
    output res_valid, res_match, res_len_err, res_timeout, digest, busy
  );

  modport slave (
    output s_data, s_valid, s_last, s_empty, exp_digest,
    output hs_din_ready, hs_dout, hs_dout_valid, hs_dout_end,
    input  s_ready, hs_start, hs_finish, hs_din, hs_din_valid, hs_din_end,
    input  res_valid, res_match, res_len_err, res_timeout, digest, busy
  );

endinterface

// File: rtl/bloke2s_digest_collect.sv
// Digest shift register with saturating byte count and comparison against a latched expected digest.
// Captures one byte per shift_en cycle; clr loads the expected value and empties the collector.
module bloke2s_digest_collect
  import bloke2s_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DFLT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      shift_en,
  input  logic [7:0]                din,
  input  logic [8*DIGEST_BYTES-1:0] exp_in,
  output logic [8*DIGEST_BYTES-1:0] digest,
  output logic                      len_ok,
  output logic                      dig_eq
);

  localparam int DW = 8 * DIGEST_BYTES;
  localparam int CW = $clog2(DIGEST_BYTES + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(DIGEST_BYTES + 1);
  localparam logic [CW-1:0] CNT_EXP = CW'(DIGEST_BYTES);

  logic [DW-1:0] dig_q, dig_d;
  logic [DW-1:0] exp_q, exp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Overflowing digests keep shifting so the newest DIGEST_BYTES bytes remain.
  always_comb begin
    dig_d = dig_q;
    exp_d = exp_q;
    cnt_d = cnt_q;
    if (clr) begin
      dig_d = '0;
      cnt_d = '0;
      exp_d = exp_in;
    end else if (shift_en) begin
      dig_d = {dig_q[DW-9:0], din};
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dig_q <= '0;
      exp_q <= '0;
      cnt_q <= '0;
    end else begin
      dig_q <= dig_d;
      exp_q <= exp_d;
      cnt_q <= cnt_d;
    end
  end

  assign digest = dig_q;
  assign len_ok = (cnt_q == CNT_EXP);
  assign dig_eq = (dig_q == exp_q);

endmodule

// File: rtl/bloke2s_host.sv
// Drives one bloke2s core per message job and checks the streamed digest; one result strobe per job.
// Message bytes pass straight through to the core (no buffering), so s_ready follows hs_din_ready in FEED.
module bloke2s_host
  import bloke2s_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DFLT,
  parameter int TIMEOUT      = 4096,
  parameter int TO_W         = 13
) (
  input  logic           clk,
  input  logic           rst,
  bloke2s_host_if.master bus
);

  localparam int DW = 8 * DIGEST_BYTES;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            tmo_q, tmo_d;

  logic            clr;
  logic            shift_en;
  logic            s_rdy;
  logic            start;
  logic            finish;
  logic            din_vld;
  logic [7:0]      din;
  logic            res_vld;
  logic [DW-1:0]   dig;
  logic            len_ok;
  logic            dig_eq;
  result_t         res;

  always_comb begin
    state_d  = state_q;
    to_d     = to_q;
    tmo_d    = tmo_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    s_rdy    = 1'b0;
    start    = 1'b0;
    finish   = 1'b0;
    din_vld  = 1'b0;
    din      = 8'h00;
    res_vld  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          clr     = 1'b1;
          tmo_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        start = 1'b1;
        // A zero-length message is acknowledged here since FEED is skipped.
        if (bus.s_valid && bus.s_empty) begin
          s_rdy   = 1'b1;
          state_d = FINISH;
        end else begin
          state_d = FEED;
        end
      end
      FEED: begin
        din_vld = bus.s_valid;
        din     = bus.s_data;
        s_rdy   = bus.hs_din_ready;
        if (bus.s_valid && bus.hs_din_ready && bus.s_last) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        finish  = 1'b1;
        to_d    = '0;
        state_d = COLLECT;
      end
      COLLECT: begin
        shift_en = bus.hs_dout_valid;
        to_d     = to_q + TO_W'(1);
        if (bus.hs_dout_end) begin
          state_d = DONE;
        end else if (to_q == TO_LAST) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        res_vld = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      to_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      tmo_q   <= tmo_d;
    end
  end

  bloke2s_digest_collect #(
    .DIGEST_BYTES(DIGEST_BYTES)
  ) u_collect (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .din      (bus.hs_dout),
    .exp_in   (bus.exp_digest),
    .digest   (dig),
    .len_ok   (len_ok),
    .dig_eq   (dig_eq)
  );

  always_comb begin
    res = '0;
    if (res_vld) begin
      res.timeout = tmo_q;
      res.len_err = !tmo_q && !len_ok;
      res.match   = !tmo_q && len_ok && dig_eq;
    end
  end

  assign bus.s_ready      = s_rdy;
  assign bus.hs_start     = start;
  assign bus.hs_finish    = finish;
  assign bus.hs_din       = din;
  assign bus.hs_din_valid = din_vld;
  assign bus.hs_din_end   = 1'b0;
  assign bus.res_valid    = res_vld;
  assign bus.res_match    = res.match;
  assign bus.res_len_err  = res.len_err;
  assign bus.res_timeout  = res.timeout;
  assign bus.digest       = dig;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bloke2s_host.sv
// Scoreboard bench for bloke2s_host with a stub core; a second instance with a short timeout covers the abort path.
`timescale 1ns/1ps
module tb_bloke2s_host;
  import bloke2s_pkg::*;

  localparam int DB = 32;
  localparam int DW = 8 * DB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bloke2s_host_if #(.DIGEST_BYTES(DB)) b ();
  bloke2s_host_if #(.DIGEST_BYTES(DB)) b2 ();

  bloke2s_host #(.DIGEST_BYTES(DB), .TIMEOUT(4096), .TO_W(13)) dut (
    .clk (clk), .rst (rst), .bus (b.master)
  );
  bloke2s_host #(.DIGEST_BYTES(DB), .TIMEOUT(16), .TO_W(5)) dut_to (
    .clk (clk), .rst (rst), .bus (b2.master)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]    msg_q[$];
  logic [7:0]    rep_q[$];
  logic [7:0]    exp_din[$];
  result_t       exp_res[$];
  logic [DW-1:0] exp_dig[$];
  logic [7:0]    din_obs[$];
  result_t       res_obs[$];
  logic [DW-1:0] dig_obs[$];

  int cyc = 0, n_start = 0, n_finish = 0, n_dinv = 0, rdy_bad = 0;
  int start_cyc = 0, finish_cyc = 0, feed_to = 0;
  result_t mon_r;

  always @(negedge clk) begin
    cyc++;
    if (b.hs_din_valid && b.hs_din_ready) din_obs.push_back(b.hs_din);
    if (b.hs_din_valid) begin
      n_dinv++;
      if (b.s_ready !== b.hs_din_ready) rdy_bad++;
    end
    if (b.hs_start)  begin n_start++;  start_cyc = cyc;  end
    if (b.hs_finish) begin n_finish++; finish_cyc = cyc; end
    if (b.res_valid) begin
      mon_r.match = b.res_match; mon_r.len_err = b.res_len_err; mon_r.timeout = b.res_timeout;
      res_obs.push_back(mon_r);
      dig_obs.push_back(b.digest);
    end
  end

  function automatic result_t mk_res(input logic m, input logic l, input logic t);
    result_t r;
    r.match = m; r.len_err = l; r.timeout = t;
    return r;
  endfunction

  function automatic logic [DW-1:0] shl(input logic [DW-1:0] a, input logic [7:0] x);
    return {a[DW-9:0], x};
  endfunction

  task automatic feed(input bit empty, input logic [DW-1:0] e);
    int nb, g;
    bit fire;
    nb = empty ? 1 : msg_q.size();
    b.exp_digest = e;
    for (int i = 0; i < nb; i++) begin
      b.s_valid = 1'b1; b.s_empty = empty; b.s_last = (i == nb - 1);
      b.s_data = empty ? 8'hEE : msg_q[i];
      fire = 1'b0; g = 0;
      while (!fire && g < 200) begin
        @(negedge clk); fire = b.s_ready;
        @(posedge clk); #1;
        b.exp_digest = ~e;
        g++;
      end
      if (!fire) feed_to++;
    end
    b.s_valid = 1'b0; b.s_empty = 1'b0; b.s_last = 1'b0; b.s_data = 8'h00;
  endtask

  task automatic drive_ready(input bit toggle);
    if (toggle) begin
      for (int i = 0; i < 16; i++) begin
        b.hs_din_ready = (i % 2 == 0);
        @(posedge clk); #1;
      end
    end
    b.hs_din_ready = 1'b1;
  endtask

  task automatic core_reply(input bit ewl);
    int g = 0;
    while (!b.hs_finish && g < 400) begin @(negedge clk); g++; end
    if (!b.hs_finish) return;
    @(posedge clk); #1;
    for (int i = 0; i < rep_q.size(); i++) begin
      b.hs_dout = rep_q[i]; b.hs_dout_valid = 1'b1;
      b.hs_dout_end = ewl && (i == rep_q.size() - 1);
      @(posedge clk); #1;
    end
    b.hs_dout_valid = 1'b0; b.hs_dout_end = 1'b0;
    if (!(ewl && rep_q.size() > 0)) begin
      b.hs_dout_end = 1'b1;
      @(posedge clk); #1;
      b.hs_dout_end = 1'b0;
    end
  endtask

  task automatic run_job(input bit empty, input logic [DW-1:0] e, input bit toggle, input bit ewl);
    fork
      feed(empty, e);
      drive_ready(toggle);
      core_reply(ewl);
    join
    for (int g = 0; g < 20 && res_obs.size() == 0; g++) begin @(posedge clk); #1; end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b.s_ready, b.hs_start, b.hs_finish, b.hs_din_valid, b.hs_din_end, b.res_valid,
         b.res_match, b.res_len_err, b.res_timeout, b.busy} !== 10'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0", {b.s_ready, b.hs_start, b.hs_finish, b.hs_din_valid,
               b.hs_din_end, b.res_valid, b.res_match, b.res_len_err, b.res_timeout, b.busy});
    end
    checks++;
    if (b.digest !== '0) begin failures++; $display("FAIL reset_digest: got %h want 0", b.digest); end
    checks++;
    if (b.hs_din !== 8'h00) begin failures++; $display("FAIL reset_din: got %h want 00", b.hs_din); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b.busy !== 1'b0 || b2.busy !== 1'b0) begin
      failures++; $display("FAIL idle_busy: got %b%b want 00", b.busy, b2.busy);
    end
  endtask

  task automatic test_abc();
    logic [DW-1:0] e = '0;
    int s0, f0;
    result_t r, er;
    logic [7:0] got, want;
    for (int i = 0; i < DB; i++) e = shl(e, 8'(i));
    msg_q = {8'h61, 8'h62, 8'h63};
    rep_q.delete();
    for (int i = 0; i < DB; i++) rep_q.push_back(8'(i));
    foreach (msg_q[i]) exp_din.push_back(msg_q[i]);
    exp_res.push_back(mk_res(1'b1, 1'b0, 1'b0));
    exp_dig.push_back(e);
    din_obs.delete(); res_obs.delete(); dig_obs.delete();
    s0 = n_start; f0 = n_finish;
    run_job(1'b0, e, 1'b0, 1'b1);
    checks++;
    if (din_obs.size() != 3) begin failures++; $display("FAIL abc_din_count: got %0d want 3", din_obs.size()); end
    while (exp_din.size() > 0) begin
      want = exp_din.pop_front();
      got = (din_obs.size() > 0) ? din_obs.pop_front() : 8'hxx;
      checks++;
      if (got !== want) begin failures++; $display("FAIL abc_din: got %h want %h", got, want); end
    end
    er = exp_res.pop_front();
    checks++;
    if (res_obs.size() == 0) begin failures++; $display("FAIL abc_res: got none want %b", er); end
    else begin
      r = res_obs.pop_front();
      if (r !== er) begin failures++; $display("FAIL abc_res: got %b want %b", r, er); end
    end
    checks++;
    if (dig_obs.size() == 0 || dig_obs[0] !== exp_dig[0]) begin
      failures++; $display("FAIL abc_digest: got %h want %h", (dig_obs.size() > 0) ? dig_obs[0] : '0, exp_dig[0]);
    end
    void'(exp_dig.pop_front());
    checks++;
    if (n_start - s0 != 1 || n_finish - f0 != 1) begin
      failures++; $display("FAIL abc_pulses: got start=%0d finish=%0d want 1 1", n_start - s0, n_finish - f0);
    end
  endtask

  task automatic test_empty();
    logic [DW-1:0] e = {DB{8'hA5}};
    int dv0, f0, ft0;
    result_t r, er;
    msg_q.delete();
    rep_q.delete();
    for (int i = 0; i < DB; i++) rep_q.push_back(8'hA5);
    exp_res.push_back(mk_res(1'b1, 1'b0, 1'b0));
    din_obs.delete(); res_obs.delete(); dig_obs.delete();
    dv0 = n_dinv; f0 = n_finish; ft0 = feed_to;
    run_job(1'b1, e, 1'b0, 1'b0);
    checks++;
    if (n_dinv != dv0 || din_obs.size() != 0) begin
      failures++; $display("FAIL empty_no_din: got %0d valid cycles want 0", n_dinv - dv0);
    end
    checks++;
    if (feed_to != ft0) begin failures++; $display("FAIL empty_consumed: got stalled beat want s_ready in START"); end
    checks++;
    if (finish_cyc - start_cyc != 1 || n_finish - f0 != 1) begin
      failures++; $display("FAIL empty_order: got finish-start=%0d finishes=%0d want 1 1", finish_cyc - start_cyc, n_finish - f0);
    end
    er = exp_res.pop_front();
    checks++;
    if (res_obs.size() == 0) begin failures++; $display("FAIL empty_res: got none want %b", er); end
    else begin
      r = res_obs.pop_front();
      if (r !== er) begin failures++; $display("FAIL empty_res: got %b want %b", r, er); end
    end
  endtask

  task automatic test_toggle();
    logic [DW-1:0] e = '0;
    int rb0;
    result_t r, er;
    logic [7:0] got, want;
    for (int i = 0; i < DB; i++) e = shl(e, 8'(i));
    msg_q = {8'h31, 8'h32, 8'h33};
    rep_q.delete();
    for (int i = 0; i < DB; i++) rep_q.push_back(8'(i));
    foreach (msg_q[i]) exp_din.push_back(msg_q[i]);
    exp_res.push_back(mk_res(1'b1, 1'b0, 1'b0));
    din_obs.delete(); res_obs.delete(); dig_obs.delete();
    rb0 = rdy_bad;
    run_job(1'b0, e, 1'b1, 1'b0);
    checks++;
    if (din_obs.size() != 3) begin failures++; $display("FAIL toggle_din_count: got %0d want 3", din_obs.size()); end
    while (exp_din.size() > 0) begin
      want = exp_din.pop_front();
      got = (din_obs.size() > 0) ? din_obs.pop_front() : 8'hxx;
      checks++;
      if (got !== want) begin failures++; $display("FAIL toggle_din: got %h want %h", got, want); end
    end
    checks++;
    if (rdy_bad != rb0) begin failures++; $display("FAIL toggle_s_ready: got %0d cycles s_ready!=hs_din_ready want 0", rdy_bad - rb0); end
    er = exp_res.pop_front();
    checks++;
    if (res_obs.size() == 0) begin failures++; $display("FAIL toggle_res: got none want %b", er); end
    else begin
      r = res_obs.pop_front();
      if (r !== er) begin failures++; $display("FAIL toggle_res: got %b want %b", r, er); end
    end
  endtask

  task automatic test_len();
    logic [DW-1:0] e, d;
    result_t r, er;
    for (int k = 0; k < 2; k++) begin
      int n = (k == 0) ? 31 : 33;
      logic [7:0] base = (k == 0) ? 8'h00 : 8'h10;
      msg_q = {8'h78};
      rep_q.delete();
      d = '0;
      for (int i = 0; i < n; i++) begin rep_q.push_back(base + 8'(i)); d = shl(d, base + 8'(i)); end
      e = (k == 0) ? d : d;
      if (k == 0) for (int i = 0; i < DB; i++) e = shl(e, 8'(i));
      exp_res.push_back(mk_res(1'b0, 1'b1, 1'b0));
      exp_dig.push_back(d);
      din_obs.delete(); res_obs.delete(); dig_obs.delete();
      run_job(1'b0, e, 1'b0, 1'b0);
      er = exp_res.pop_front();
      checks++;
      if (res_obs.size() == 0) begin failures++; $display("FAIL len%0d_res: got none want %b", n, er); end
      else begin
        r = res_obs.pop_front();
        if (r !== er) begin failures++; $display("FAIL len%0d_res: got %b want %b", n, r, er); end
      end
      checks++;
      if (dig_obs.size() == 0 || dig_obs[0] !== exp_dig[0]) begin
        failures++; $display("FAIL len%0d_digest: got %h want %h", n, (dig_obs.size() > 0) ? dig_obs[0] : '0, exp_dig[0]);
      end
      void'(exp_dig.pop_front());
    end
  endtask

  task automatic test_timeout();
    int c = 0, fin_c = -1, res_c = -1;
    bit drop = 1'b0;
    result_t r, er;
    exp_res.push_back(mk_res(1'b0, 1'b0, 1'b1));
    r = '0;
    b2.hs_din_ready = 1'b1; b2.s_valid = 1'b1; b2.s_empty = 1'b1; b2.s_last = 1'b1;
    while (res_c < 0 && c < 100) begin
      @(negedge clk); c++;
      if (b2.s_ready) drop = 1'b1;
      if (b2.hs_finish) fin_c = c;
      if (b2.res_valid) begin
        res_c = c; r.match = b2.res_match; r.len_err = b2.res_len_err; r.timeout = b2.res_timeout;
      end
      @(posedge clk); #1;
      if (drop) begin b2.s_valid = 1'b0; b2.s_empty = 1'b0; b2.s_last = 1'b0; end
    end
    checks++;
    if (res_c < 0 || fin_c < 0 || res_c - fin_c != 17) begin
      failures++; $display("FAIL timeout_latency: got res at %0d finish at %0d want res 17 after finish", res_c, fin_c);
    end
    er = exp_res.pop_front();
    checks++;
    if (r !== er) begin failures++; $display("FAIL timeout_res: got %b want %b", r, er); end
    checks++;
    if (b2.busy !== 1'b0 || b2.res_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_idle: got busy=%b res_valid=%b want 0 0", b2.busy, b2.res_valid);
    end
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] e = '0;
    int r0, f0;
    result_t r, er;
    for (int i = 0; i < DB; i++) e = shl(e, 8'(i));
    b.exp_digest = e; b.hs_din_ready = 1'b1;
    b.s_valid = 1'b1; b.s_data = 8'h61; b.s_last = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (b.hs_din_valid !== 1'b1) begin failures++; $display("FAIL abort_in_feed: got hs_din_valid=%b want 1", b.hs_din_valid); end
    rst = 1'b0; b.s_valid = 1'b0;
    r0 = res_obs.size(); f0 = n_finish;
    @(posedge clk); #1;
    checks++;
    if ({b.s_ready, b.hs_start, b.hs_finish, b.hs_din_valid, b.res_valid, b.busy} !== 6'b0 || b.digest !== '0) begin
      failures++; $display("FAIL abort_reset_outputs: got %b digest %h want 0",
                           {b.s_ready, b.hs_start, b.hs_finish, b.hs_din_valid, b.res_valid, b.busy}, b.digest);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (res_obs.size() != r0 || n_finish != f0) begin
      failures++; $display("FAIL abort_silent: got %0d results %0d finishes want 0 0", res_obs.size() - r0, n_finish - f0);
    end
    msg_q = {8'h61, 8'h62, 8'h63};
    rep_q.delete();
    for (int i = 0; i < DB; i++) rep_q.push_back(8'(i));
    exp_res.push_back(mk_res(1'b1, 1'b0, 1'b0));
    din_obs.delete(); res_obs.delete(); dig_obs.delete();
    run_job(1'b0, e, 1'b0, 1'b0);
    er = exp_res.pop_front();
    checks++;
    if (res_obs.size() == 0) begin failures++; $display("FAIL abort_next_res: got none want %b", er); end
    else begin
      r = res_obs.pop_front();
      if (r !== er) begin failures++; $display("FAIL abort_next_res: got %b want %b", r, er); end
    end
    checks++;
    if (din_obs.size() != 3) begin failures++; $display("FAIL abort_next_din: got %0d bytes want 3", din_obs.size()); end
  endtask

  initial begin
    b.s_data = 8'h00; b.s_valid = 1'b0; b.s_last = 1'b0; b.s_empty = 1'b0; b.exp_digest = '0;
    b.hs_din_ready = 1'b1; b.hs_dout = 8'h00; b.hs_dout_valid = 1'b0; b.hs_dout_end = 1'b0;
    b2.s_data = 8'h00; b2.s_valid = 1'b0; b2.s_last = 1'b0; b2.s_empty = 1'b0; b2.exp_digest = '0;
    b2.hs_din_ready = 1'b1; b2.hs_dout = 8'h00; b2.hs_dout_valid = 1'b0; b2.hs_dout_end = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_toggle();
    test_len();
    test_timeout();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bloke2s_host.md
Name: bloke2s_host

Overview:
- Hardware initiator for the bloke2s hash core's start/finish/din/dout protocol; replaces the bench-driven sequence in silicon.
- Takes one message per job from an upstream byte stream and drives start, din and finish on the core.
- Collects the streamed digest, compares it against an expected digest and reports one result per job.
- Sits between a command/message source (e.g. CPU-facing FIFO) and one bloke2s instance.

Parameters:
- DIGEST_BYTES, 32, digest length in bytes; sets collector width of 8*DIGEST_BYTES.
- TIMEOUT, 4096, maximum cycles allowed from finish pulse to dout_end before the job aborts.
- TO_W, 13, timeout counter width; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- s_data  in  8  message byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  byte accepted on the edge where s_valid&&s_ready.
- s_last  in  1  final byte of message.
- s_empty  in  1  with s_valid: zero-length message; s_data ignored.
- exp_digest  in  8*DIGEST_BYTES  expected digest, first-received byte in MSBs; sampled at job start.
- hs_start  out  1  core start pulse.
- hs_finish  out  1  core finish pulse.
- hs_din  out  8  byte to core.
- hs_din_valid  out  1  hs_din valid.
- hs_din_ready  in  1  core accepts a byte on the edge where hs_din_valid&&hs_din_ready.
- hs_din_end  out  1  tied 0 (reserved).
- hs_dout  in  8  digest byte from core.
- hs_dout_valid  in  1  hs_dout valid.
- hs_dout_end  in  1  digest complete.
- res_valid  out  1  one-cycle result strobe.
- res_match  out  1  digest equals exp_digest, byte count correct and no timeout.
- res_len_err  out  1  digest byte count differs from DIGEST_BYTES.
- res_timeout  out  1  hs_dout_end missing within TIMEOUT cycles.
- digest  out  8*DIGEST_BYTES  collected digest; held until the next job starts.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; all outputs 0, including digest. Reset mid-job aborts with no res_valid and no hs_finish.
- IDLE:
  - s_ready=0.
  - On s_valid: latch exp_digest, clear digest and counters, go to START.
  - The first byte is not consumed in IDLE.
- START: hs_start=1 for exactly one cycle; next state FEED, or FINISH if s_empty is set. An empty message consumes its s_valid beat via s_ready=1 in this cycle.
- FEED:
  - hs_din=s_data, hs_din_valid=s_valid, s_ready=hs_din_ready (combinational pass-through, no skid buffer).
  - On a transfer with s_last: go to FINISH.
  - hs_din_valid is never asserted outside FEED.
- FINISH: hs_finish=1 for exactly one cycle; clear the timeout counter; go to COLLECT.
- COLLECT:
  - Each cycle with hs_dout_valid: digest <= {digest[8*DIGEST_BYTES-9:0], hs_dout}; byte count increments and saturates at DIGEST_BYTES+1.
  - hs_dout_valid and hs_dout_end in the same cycle: the byte is captured first, then the job ends.
  - On hs_dout_end: go to DONE.
  - Timeout counter increments each cycle; reaching TIMEOUT sets the timeout flag and goes to DONE.
- DONE:
  - res_valid=1 for one cycle with flags valid that cycle; next state IDLE.
  - res_match=1 iff no timeout and count==DIGEST_BYTES and digest==latched exp_digest.
  - res_len_err=1 iff count!=DIGEST_BYTES and no timeout.
  - Digest overflow keeps the last DIGEST_BYTES bytes.
- Back-to-back jobs: earliest next hs_start is 2 cycles after res_valid (DONE→IDLE→START).
- hs_dout_valid outside COLLECT is ignored.

Decomposition:
- Package bloke2s_pkg holds:
  - state enum {IDLE, START, FEED, FINISH, COLLECT, DONE};
  - DIGEST_BYTES default;
  - result struct {match, len_err, timeout}.
- One natural sub-module: bloke2s_digest_collect (shift register, byte counter, comparator), reusable by a future host-side checker.

Test Plan:
- Stub core (din_ready always 1, returns bytes 0x00..0x1F then dout_end), message "abc", exp=0x00..1F → hs_din 0x61,0x62,0x63 in order, one hs_finish, res_valid with match=1, len_err=0, timeout=0.
- Empty message (s_empty=1), stub returns 32 bytes 0xA5 vs exp all 0xA5 → no hs_din_valid, hs_start then hs_finish, match=1.
- Stub din_ready toggling 1-0-1, message "123" → exactly 3 transfers, no byte duplicated or dropped, s_ready equals hs_din_ready.
- Stub returns 31 bytes then dout_end → len_err=1, match=0. Stub returns 33 bytes → digest = last 32 bytes, len_err=1.
- Stub never asserts dout_end, TIMEOUT=16 → res_valid 16 cycles after the COLLECT entry, timeout=1, match=0, then busy=0.
- Reset asserted mid-FEED, then job "abc" → outputs 0 during reset, no res_valid for the aborted job, second job matches.
